// File: rtl/a2d_spi_resp_if.sv
// SPI link between the IR interface master and the A2D responder.
// Mode 0 framing; SS_n, SCLK and MOSI come from the master, MISO goes back.
interface a2d_spi_resp_if;
   logic SS_n;
   logic SCLK;
   logic MOSI;
   logic MISO;

   modport master (output SS_n, output SCLK, output MOSI, input MISO);
   modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_resp.sv
// SPI responder standing in for the 8-channel 12-bit A2D: decodes the channel
// command of each 16-bit frame and returns the previously commanded channel.
module a2d_spi_resp #(
   parameter logic [2:0] RESET_CHNL = 3'd0
) (
   input  logic                clk,
   input  logic                rst,
   a2d_spi_resp_if.slave       spi,
   input  logic [95:0]         ana_vals,
   output logic [2:0]          cmd_chnl,
   output logic                done,
   output logic                frm_err
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;

   logic [2:0]  ss_n_sync_r;
   logic [2:0]  sclk_sync_r;
   logic [1:0]  mosi_sync_r;
   logic        ss_fall_s;
   logic        ss_rise_s;
   logic        sclk_rise_s;
   logic        sclk_fall_s;

   logic [15:0] tx_shft_r;
   logic [15:0] tx_shft_nxt_s;
   // Only the low 14 received bits are kept: the command lives in [13:11].
   logic [13:0] rx_shft_r;
   logic [13:0] rx_shft_nxt_s;
   logic [4:0]  bit_cnt_r;
   logic [4:0]  bit_cnt_nxt_s;
   logic [2:0]  chnl_nxt_r;
   logic [2:0]  chnl_upd_s;
   logic [2:0]  cmd_chnl_s;
   logic        done_s;
   logic        frm_err_s;
   logic        miso_r;
   logic        miso_s;

   function automatic logic [11:0] chnl_val(input logic [95:0] vals, input logic [2:0] chnl);
      logic [11:0] v;
      case (chnl)
         3'd0:    v = vals[11:0];
         3'd1:    v = vals[23:12];
         3'd2:    v = vals[35:24];
         3'd3:    v = vals[47:36];
         3'd4:    v = vals[59:48];
         3'd5:    v = vals[71:60];
         3'd6:    v = vals[83:72];
         3'd7:    v = vals[95:84];
         default: v = 12'd0;
      endcase
      return v;
   endfunction

   assign ss_fall_s   = ~ss_n_sync_r[1] &  ss_n_sync_r[2];
   assign ss_rise_s   =  ss_n_sync_r[1] & ~ss_n_sync_r[2];
   assign sclk_rise_s =  sclk_sync_r[1] & ~sclk_sync_r[2];
   assign sclk_fall_s = ~sclk_sync_r[1] &  sclk_sync_r[2];

   assign spi.MISO    = miso_r;

   // Synchronize the SPI inputs; SS_n resetting low means a line held low through reset never looks like a fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_n_sync_r <= 3'b000;
         sclk_sync_r <= 3'b000;
         mosi_sync_r <= 2'b00;
      end else begin
         ss_n_sync_r <= {ss_n_sync_r[1:0], spi.SS_n};
         sclk_sync_r <= {sclk_sync_r[1:0], spi.SCLK};
         mosi_sync_r <= {mosi_sync_r[0], spi.MOSI};
      end
   end

   // Frame state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state, shift registers and frame-end decode.
   always_comb begin
      state_nxt_s   = state_r;
      tx_shft_nxt_s = tx_shft_r;
      rx_shft_nxt_s = rx_shft_r;
      bit_cnt_nxt_s = bit_cnt_r;
      chnl_upd_s    = chnl_nxt_r;
      cmd_chnl_s    = cmd_chnl;
      done_s        = 1'b0;
      frm_err_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (ss_fall_s) begin
               tx_shft_nxt_s = {4'b0000, chnl_val(ana_vals, chnl_nxt_r)};
               rx_shft_nxt_s = 14'd0;
               bit_cnt_nxt_s = 5'd0;
               state_nxt_s   = SHIFT;
            end else begin
               state_nxt_s   = IDLE;
            end
         end
         SHIFT: begin
            if (sclk_rise_s) begin
               rx_shft_nxt_s = {rx_shft_r[12:0], mosi_sync_r[1]};
               bit_cnt_nxt_s = (bit_cnt_r == 5'd31) ? 5'd31 : (bit_cnt_r + 5'd1);
            end else begin
               rx_shft_nxt_s = rx_shft_r;
               bit_cnt_nxt_s = bit_cnt_r;
            end
            if (sclk_fall_s) begin
               tx_shft_nxt_s = {tx_shft_r[14:0], 1'b0};
            end else begin
               tx_shft_nxt_s = tx_shft_r;
            end
            // A rise coinciding with SS_n rise is already folded into the count checked here.
            if (ss_rise_s) begin
               state_nxt_s = IDLE;
               if (bit_cnt_nxt_s == 5'd16) begin
                  chnl_upd_s = rx_shft_nxt_s[13:11];
                  cmd_chnl_s = rx_shft_nxt_s[13:11];
                  done_s     = 1'b1;
               end else begin
                  frm_err_s  = 1'b1;
               end
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
      miso_s = (state_nxt_s == SHIFT) ? tx_shft_nxt_s[15] : 1'b1;
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_shft_r  <= 16'd0;
         rx_shft_r  <= 14'd0;
         bit_cnt_r  <= 5'd0;
         chnl_nxt_r <= RESET_CHNL;
         cmd_chnl   <= RESET_CHNL;
         done       <= 1'b0;
         frm_err    <= 1'b0;
         miso_r     <= 1'b1;
      end else begin
         tx_shft_r  <= tx_shft_nxt_s;
         rx_shft_r  <= rx_shft_nxt_s;
         bit_cnt_r  <= bit_cnt_nxt_s;
         chnl_nxt_r <= chnl_upd_s;
         cmd_chnl   <= cmd_chnl_s;
         done       <= done_s;
         frm_err    <= frm_err_s;
         miso_r     <= miso_s;
      end
   end

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Randomized bench for a2d_spi_resp: a bus-functional SPI master pushes expected
// frame results into a scoreboard; a monitor pops them on each done/frm_err pulse.
module tb_a2d_spi_resp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [95:0] ana_vals = 96'd0;
   logic [2:0]  cmd_chnl;
   logic        done;
   logic        frm_err;

   a2d_spi_resp_if spi ();

   a2d_spi_resp #(.RESET_CHNL(3'd0)) dut (
      .clk      (clk),
      .rst      (rst),
      .spi      (spi.slave),
      .ana_vals (ana_vals),
      .cmd_chnl (cmd_chnl),
      .done     (done),
      .frm_err  (frm_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          err;
      logic [2:0]  chnl;
      logic [31:0] bits;
      int          n;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;

   // Reference model: channel values and the last successfully commanded channel.
   logic [11:0] vals [8];
   logic [2:0]  chnl_prev = 3'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic set_val(input logic [2:0] ch, input logic [11:0] v);
      vals[ch] = v;
      ana_vals[ch*12 +: 12] = v;
   endtask

   // One master frame of n bits; optional mid-frame ana_vals change; optional SS_n rise with last SCLK rise.
   task automatic frame(input logic [15:0] mosi, input int n, input int chg_bit,
                        input logic [2:0] chg_ch, input logic [11:0] chg_val, input bit simul);
      exp_t        e;
      logic [31:0] r;
      r      = {20'd0, vals[chnl_prev]};
      e.err  = (n != 16);
      e.chnl = (n == 16) ? mosi[13:11] : chnl_prev;
      e.n    = n;
      e.bits = (n <= 16) ? (r >> (16 - n)) : (r << (n - 16));
      sb.push_back(e);
      spi.SS_n = 1'b0;
      tick(6);
      for (int i = 0; i < n; i++) begin
         spi.MOSI = (i < 16) ? mosi[15 - i] : 1'b0;
         tick(5);
         spi.SCLK = 1'b1;
         if (simul && i == n - 1) spi.SS_n = 1'b1;
         tick(5);
         spi.SCLK = 1'b0;
         if (i == chg_bit) set_val(chg_ch, chg_val);
      end
      if (!simul) begin
         tick(6);
         spi.SS_n = 1'b1;
      end
      tick(8);
      if (n == 16) chnl_prev = mosi[13:11];
      chk("sb_drained", sb.size(), 0);
   endtask

   // Monitor: rebuilds what the master sampled on MISO and scores each frame-end pulse.
   logic        ss_prev = 1'b1;
   logic        sclk_prev = 1'b0;
   logic [31:0] coll = 32'd0;
   int          ncoll = 0;
   always @(negedge clk) begin
      exp_t e;
      if (ss_prev && !spi.SS_n) begin
         coll  = 32'd0;
         ncoll = 0;
      end
      if (!sclk_prev && spi.SCLK && !ss_prev) begin
         coll = {coll[30:0], spi.MISO};
         ncoll++;
      end
      if (!rst && (done || frm_err)) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {30'd0, done, frm_err}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("frm_err", {31'd0, frm_err}, {31'd0, e.err});
            chk("done", {31'd0, done}, {31'd0, !e.err});
            chk("cmd_chnl", {29'd0, cmd_chnl}, {29'd0, e.chnl});
            chk("miso_bits", coll, e.bits);
            chk("bit_count", ncoll, e.n);
         end
      end
      ss_prev   = spi.SS_n;
      sclk_prev = spi.SCLK;
   end

   initial begin
      int n;
      int cb;
      spi.SS_n = 1'b1;
      spi.SCLK = 1'b0;
      spi.MOSI = 1'b0;
      for (int c = 0; c < 8; c++) set_val(c[2:0], 12'($urandom));
      tick(4);
      chk("rst_miso", {31'd0, spi.MISO}, 32'd1);
      chk("rst_cmd_chnl", {29'd0, cmd_chnl}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_frm_err", {31'd0, frm_err}, 32'd0);
      rst = 1'b0;
      tick(6);

      // First frame after reset returns channel 0.
      set_val(3'd0, 12'hABC);
      frame(16'h0000, 16, -1, 3'd0, 12'd0, 1'b0);
      // Channel pipeline: command 5, then read it back.
      set_val(3'd5, 12'h123);
      frame(16'h2800, 16, -1, 3'd0, 12'd0, 1'b0);
      chk("cmd_after_a", {29'd0, cmd_chnl}, 32'd5);
      frame(16'h1000, 16, -1, 3'd0, 12'd0, 1'b0);
      // Short frame leaves the command (channel 2) in place.
      frame(16'h3800, 12, -1, 3'd0, 12'd0, 1'b0);
      frame(16'h0000, 16, -1, 3'd0, 12'd0, 1'b0);
      // Snapshot: channel 0 changes after bit 4.
      set_val(3'd0, 12'h555);
      frame(16'h3000, 16, 4, 3'd0, 12'hFFF, 1'b0);
      // SS_n rising together with the 16th SCLK rise still counts as a full frame.
      frame(16'h4800, 16, -1, 3'd0, 12'd0, 1'b1);
      frame(16'h0000, 16, -1, 3'd0, 12'd0, 1'b0);

      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 1) == 0) set_val(3'($urandom_range(0, 7)), 12'($urandom));
         if ($urandom_range(0, 3) != 0) begin
            n = 16;
         end else begin
            n = $urandom_range(1, 19);
            if (n >= 16) n++;
         end
         cb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
         frame(16'($urandom), n, cb, 3'($urandom_range(0, 7)), 12'($urandom),
               ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
      end

      // Reset mid-frame with SS_n held low through release.
      frame(16'h3000, 16, -1, 3'd0, 12'd0, 1'b0);
      spi.SS_n = 1'b0;
      tick(6);
      for (int i = 0; i < 16; i++) begin
         spi.MOSI = 1'($urandom);
         tick(5);
         spi.SCLK = 1'b1;
         tick(5);
         spi.SCLK = 1'b0;
         if (i == 6) begin
            #1 rst = 1'b1;
            #1;
            chk("async_miso", {31'd0, spi.MISO}, 32'd1);
            chk("async_cmd_chnl", {29'd0, cmd_chnl}, 32'd0);
            chk("async_done", {31'd0, done}, 32'd0);
            chk("async_frm_err", {31'd0, frm_err}, 32'd0);
            tick(3);
            rst = 1'b0;
            chnl_prev = 3'd0;
         end else if (i > 6) begin
            chk("idle_miso", {31'd0, spi.MISO}, 32'd1);
         end
      end
      tick(6);
      spi.SS_n = 1'b1;
      tick(8);
      chk("no_pulse_after_rst", sb.size(), 0);
      set_val(3'd0, 12'h9A7);
      frame(16'h0800, 16, -1, 3'd0, 12'd0, 1'b0);
      frame(16'h0000, 16, -1, 3'd0, 12'd0, 1'b0);

      tick(10);
      chk("sb_final", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/a2d_spi_resp.md
# a2d_spi_resp

Synthesizable SPI responder that models the 8-channel, 12-bit A2D converter on the far end of the IR sensor interface's SPI link. It accepts 16-bit mode-0 frames from the SPI master in the IR interface and decodes the channel command from each frame. It returns a 12-bit conversion value, snapshotted from a parallel input bus, for the channel commanded in the previous frame. It is used in the full-chip testbench and in FPGA bring-up in place of the physical A2D.

## Interface
- RESET_CHNL, 3'd0, channel converted in the first frame after reset.
- clk  in  1  system clock; the only clock; SCLK is treated as data.
- rst  in  1  asynchronous, active-high reset.
- SS_n  in  1  SPI slave select, active low; asynchronous to clk.
- SCLK  in  1  SPI clock, mode 0, idles low; asynchronous to clk.
- MOSI  in  1  SPI command data from the master.
- MISO  out  1  SPI response data; registered.
- ana_vals  in  96  channel n value at [12n+11:12n].
- cmd_chnl  out  3  channel field captured from the last valid frame.
- done  out  1  one-clk pulse when a valid 16-bit frame ends.
- frm_err  out  1  one-clk pulse when a frame ends with a bit count other than 16.

## Operation
- Synchronizers:
  - SS_n, SCLK and MOSI each pass through 2 flops, plus a 3rd flop for edge detection.
  - Rise detection is sync2 & ~sync3; fall detection is ~sync2 & sync3.
  - SS_n stages reset to 0. SCLK stages reset to 0. MOSI stages reset to 0.
- State machine states: IDLE and SHIFT. Reset state is IDLE.
- IDLE:
  - MISO = 1.
  - SS_n rise is ignored.
  - On SS_n fall:
    - Load tx_shft[15:0] = {4'b0000, ana_vals[12*chnl_nxt +: 12]}.
    - Clear rx_shft and bit_cnt.
    - Go to SHIFT.
- SHIFT:
  - MISO = tx_shft[15].
  - On SCLK rise: rx_shft <= {rx_shft[14:0], MOSI_sync}. bit_cnt (5 bits) increments and saturates at 31.
  - On SCLK fall: tx_shft <= {tx_shft[14:0], 1'b0}.
  - On SS_n rise, if bit_cnt == 16:
    - chnl_nxt <= rx_shft[13:11].
    - cmd_chnl <= rx_shft[13:11].
    - Pulse done.
  - On SS_n rise, if bit_cnt != 16:
    - Pulse frm_err.
    - chnl_nxt and cmd_chnl are unchanged.
  - On SS_n rise, go to IDLE in all cases.
- Pipelined channel semantics: frame k returns the channel commanded in frame k-1. Command bits other than [13:11] are ignored.
- ana_vals is sampled only at frame start. Changes during a frame do not affect the current response.
- Simultaneous SCLK rise and SS_n rise in the same clk:
  - The SCLK rise is applied first.
  - The bit_cnt check uses the incremented count.
- SCLK edges seen in IDLE are ignored.
- Reset values: MISO=1, cmd_chnl=RESET_CHNL, chnl_nxt=RESET_CHNL, done=0, frm_err=0, bit_cnt=0, tx_shft=0, rx_shft=0.
- Reset mid-frame:
  - All registers return to their reset values.
  - After release, no frame starts until a synchronized SS_n fall is seen. If SS_n is held low through reset release, this requires SS_n to go high and then low again.

## Timing
- Input requirements on the master:
  - SCLK high and low phases ≥ 4 clk each.
  - SS_n fall to first SCLK rise ≥ 4 clk.
  - Last SCLK fall to SS_n rise ≥ 4 clk.
  - SS_n high time between frames ≥ 4 clk.
- Latencies, counted from the first clk edge that samples the input change:
  - SS_n fall to MISO showing tx bit 15: 3 clk.
  - SCLK fall to the next MISO bit: 3 clk.
  - SS_n rise to done/frm_err pulse: 3 clk; the pulse is exactly 1 clk wide.
  - SS_n rise to cmd_chnl update: 3 clk, on the same edge as done.
- MISO is stable from one SCLK fall until 3 clk after the next SCLK fall. This guarantees a stable value at the master's SCLK rise.

## Test plan
- Reset test:
  - Stimulus: assert rst mid-stream.
  - Required: MISO=1, cmd_chnl=0, done=0 and frm_err=0 asynchronously, with no clk edge needed.
- First frame after reset:
  - Stimulus: ana_vals ch0=12'hABC; master sends MOSI 16'h0000 over 16 SCLKs.
  - Required: master receives 16'h0ABC; one done pulse; cmd_chnl=0.
- Channel pipeline:
  - Stimulus: frame A with MOSI 16'h2800 (channel 5); ch5=12'h123.
  - Required: after frame A, cmd_chnl=5. Frame B returns 16'h0123.
- Short frame:
  - Stimulus: 12 SCLKs, then SS_n rises.
  - Required: one frm_err pulse, no done pulse, cmd_chnl unchanged. The next full frame still returns the previously commanded channel.
- Snapshot:
  - Stimulus: ch0=12'h555 at frame start; change it to 12'hFFF after bit 4.
  - Required: master receives 16'h0555.
- Reset mid-frame:
  - Stimulus: rst pulses at bit 7 while SS_n stays low through release.
  - Required: MISO=1 and no done pulse. A subsequent full frame after SS_n toggles high then low returns channel RESET_CHNL's value.
